// File: rtl/edge_write_packer.sv
// edge_write_packer
// Turns the one-bit-per-pixel hysteresis result into 8-bit pixels and writes
// them to the output SRAM in raster order. A small bit FIFO absorbs SRAM
// stalls. Frame completion and sticky overflow/excess-input errors are reported
// to the main controller.
// Optional feature macro: BORDER_ZERO_EN -- when defined, pixels within BORDER
// of any image edge are written as 8'h00 regardless of the edge bit.
module edge_write_packer #(
    parameter int         IMG_W      = 512,
    parameter int         IMG_H      = 512,
    parameter int         ADDR_W     = 18,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] EDGE_VAL   = 8'hFF,
    parameter int         BORDER     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              edge_valid,
    input  logic              edge_bit,
    input  logic              write_ready,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_address,
    output logic [7:0]        write_data,
    output logic              busy,
    output logic              frame_done,
    output logic              error
);

    localparam int NPIX  = IMG_W * IMG_H;
    // One spare bit so the counters can represent a full frame count.
    localparam int CNT_W = ADDR_W + 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(NPIX - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    // Reject configurations the address space or FIFO pointers cannot represent.
    generate
        if ((IMG_W * IMG_H > (1 << ADDR_W)) || (FIFO_DEPTH < 2) ||
            ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (BORDER < 0)) begin : g_bad_params
            $error("edge_write_packer: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic [CNT_W-1:0]  r_in_cnt;
    logic [CNT_W-1:0]  r_wr_cnt;
    logic              r_write_enable;
    logic [ADDR_W-1:0] r_write_address;
    logic [7:0]        r_write_data;
    logic              r_error;

    logic w_active;
    logic w_full;
    logic w_pop;
    logic w_push_req;
    logic w_push;
    logic w_overflow;
    logic w_excess;
    logic w_fifo_bit;
    logic w_pix_bit;

    assign w_active   = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_full     = (r_count == FULL_CNT);
    assign w_pop      = w_active && (r_count != '0) && write_ready;
    // Every valid input in RUN counts toward the frame, even if it is dropped.
    assign w_push_req = (r_state == ST_RUN) && edge_valid;
    // A push at full is fine as long as a pop frees a slot in the same cycle.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_overflow = w_push_req && w_full && !w_pop;
    assign w_excess   = (r_state == ST_DRAIN) && edge_valid;
    assign w_fifo_bit = r_fifo_mem[r_rd_ptr];

`ifdef BORDER_ZERO_EN
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = $clog2(IMG_H + 1);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             w_border;

    // Column/row position of the pixel that the next pop will write.
    always_ff @(posedge clk) begin
        if (rst || frame_start) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_pop) begin
            if (r_col == COL_W'(IMG_W - 1)) begin
                r_col <= '0;
                r_row <= r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    assign w_border  = (int'(r_col) < BORDER) || (int'(r_col) >= IMG_W - BORDER) ||
                       (int'(r_row) < BORDER) || (int'(r_row) >= IMG_H - BORDER);
    assign w_pix_bit = w_fifo_bit && !w_border;
`else
    assign w_pix_bit = w_fifo_bit;
`endif

    // FIFO storage: plain array, written on accepted pushes only.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= edge_bit;
        end
    end

    // Frame state machine; frame_start restarts from any state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else if (frame_start) begin
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_IDLE:  r_state <= ST_IDLE;
                ST_RUN:   if (w_push_req && (r_in_cnt == LAST_IN)) r_state <= ST_DRAIN;
                // Empty FIFO here means the final pop already went out last cycle.
                ST_DRAIN: if (r_count == '0) r_state <= ST_DONE;
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // FIFO pointers, occupancy, input pixel count and the sticky error flag.
    always_ff @(posedge clk) begin
        if (rst || frame_start) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_in_cnt <= '0;
            r_error  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_push_req) r_in_cnt <= r_in_cnt + CNT_W'(1);
            if (w_overflow || w_excess) r_error <= 1'b1;
        end
    end

    // Registered SRAM write port; address and data hold between strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write_enable  <= 1'b0;
            r_write_address <= '0;
            r_write_data    <= 8'h00;
            r_wr_cnt        <= '0;
        end else if (frame_start) begin
            r_write_enable  <= 1'b0;
            r_wr_cnt        <= '0;
        end else begin
            r_write_enable <= w_pop;
            if (w_pop) begin
                r_write_address <= r_wr_cnt[ADDR_W-1:0];
                r_write_data    <= w_pix_bit ? EDGE_VAL : 8'h00;
                r_wr_cnt        <= r_wr_cnt + CNT_W'(1);
            end
        end
    end

    assign write_enable  = r_write_enable;
    assign write_address = r_write_address;
    assign write_data    = r_write_data;
    assign busy          = w_active;
    assign frame_done    = (r_state == ST_DONE);
    assign error         = r_error;

endmodule

// File: tb/tb_edge_write_packer.sv
// Directed testbench for edge_write_packer on a 4x4 image with a 4-entry FIFO.
// A negedge monitor logs every write strobe and frame_done pulse; the main
// initial block drives frames and compares the log against hand expectations.
module tb_edge_write_packer;

    localparam int         IMG_W      = 4;
    localparam int         IMG_H      = 4;
    localparam int         ADDR_W     = 4;
    localparam int         FIFO_DEPTH = 4;
    localparam logic [7:0] EDGE_VAL   = 8'hFF;
    localparam int         BORDER     = 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_start;
    logic              edge_valid;
    logic              edge_bit;
    logic              write_ready;
    logic              write_enable;
    logic [ADDR_W-1:0] write_address;
    logic [7:0]        write_data;
    logic              busy;
    logic              frame_done;
    logic              error;

    edge_write_packer #(
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .EDGE_VAL   (EDGE_VAL),
        .BORDER     (BORDER)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .edge_valid    (edge_valid),
        .edge_bit      (edge_bit),
        .write_ready   (write_ready),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data),
        .busy          (busy),
        .frame_done    (frame_done),
        .error         (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Write / frame_done log
    int wlog_addr [256];
    int wlog_data [256];
    int wlog_cyc  [256];
    int n_wr   = 0;
    int n_done = 0;

    always @(negedge clk) begin
        if (write_enable && n_wr < 256) begin
            wlog_addr[n_wr] = int'(write_address);
            wlog_data[n_wr] = int'(write_data);
            wlog_cyc[n_wr]  = cyc;
            $display("write  cyc=%0d addr=%0d data=%02h", cyc, write_address, write_data);
            n_wr = n_wr + 1;
        end
        if (frame_done) begin
            $display("frame_done cyc=%0d", cyc);
            n_done = n_done + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic b, input logic r);
        edge_valid  = v;
        edge_bit    = b;
        write_ready = r;
        step();
    endtask

    task automatic start_frame();
        edge_valid  = 1'b0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int dbase);
        edge_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (n_done != dbase) break;
            step();
        end
        step(); step(); step();
    endtask

    function automatic logic [7:0] exp_data(input int addr, input logic b);
        logic bord;
`ifdef BORDER_ZERO_EN
        int row, col;
        row  = addr / IMG_W;
        col  = addr % IMG_W;
        bord = (col < BORDER) || (col >= IMG_W - BORDER) ||
               (row < BORDER) || (row >= IMG_H - BORDER);
`else
        bord = 1'b0;
`endif
        return (b && !bord) ? EDGE_VAL : 8'h00;
    endfunction

    task automatic chk_writes(input string tag, input int base, input int nexp,
                              input logic [15:0] kept);
        chk({tag, " count"}, n_wr - base, nexp);
        for (int i = 0; i < nexp && base + i < n_wr; i++) begin
            chk($sformatf("%s addr%0d", tag, i), wlog_addr[base + i], i);
            chk($sformatf("%s data%0d", tag, i), wlog_data[base + i],
                32'(exp_data(i, kept[i])));
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, " write_enable"},  write_enable,  0);
        chk({tag, " write_address"}, write_address, 0);
        chk({tag, " write_data"},    write_data,    0);
        chk({tag, " busy"},          busy,          0);
        chk({tag, " frame_done"},    frame_done,    0);
        chk({tag, " error"},         error,         0);
    endtask

    initial begin
        logic [15:0] bits;
        int wbase, dbase, c0;

        rst = 1'b1; frame_start = 1'b0; edge_valid = 1'b0; edge_bit = 1'b0; write_ready = 1'b0;
        step(); step();
        chk_idle_outputs("reset");
        rst = 1'b0;
        step();

        // Basic frame: alternating 1,0 with the SRAM always ready
        bits = 16'h5555;
        start_frame();
        chk("basic busy", busy, 1);
        wbase = n_wr; dbase = n_done; c0 = cyc;
        for (int i = 0; i < 16; i++) drive(1'b1, bits[i], 1'b1);
        wait_done(dbase);
        chk_writes("basic", wbase, 16, bits);
        chk("basic latency", wlog_cyc[wbase] - c0, 2);
        chk("basic done count", n_done - dbase, 1);
        chk("basic error", error, 0);
        chk("basic busy after", busy, 0);

        // Backpressure: four pushes into an empty FIFO while write_ready=0
        bits = 16'hA5C3;
        start_frame();
        wbase = n_wr; dbase = n_done;
        drive(1'b1, bits[0], 1'b1);
        drive(1'b1, bits[1], 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        for (int i = 2; i < 6; i++) drive(1'b1, bits[i], 1'b0);
        chk("stall error", error, 0);
        chk("stall writes", n_wr - wbase, 2);
        chk("stall write_enable", write_enable, 0);
        for (int i = 6; i < 16; i++) drive(1'b1, bits[i], 1'b1);
        wait_done(dbase);
        chk_writes("bp", wbase, 16, bits);
        chk("bp gap", wlog_cyc[wbase + 2] - wlog_cyc[wbase + 1], 5);
        chk("bp burst", wlog_cyc[wbase + 5] - wlog_cyc[wbase + 2], 3);
        chk("bp done count", n_done - dbase, 1);
        chk("bp error", error, 0);

        // Overflow: fifth push while full and stalled is dropped
        bits = 16'hB6D3;
        start_frame();
        wbase = n_wr; dbase = n_done;
        for (int i = 0; i < 4; i++) drive(1'b1, bits[i], 1'b0);
        chk("ovf error before", error, 0);
        drive(1'b1, bits[4], 1'b0);
        chk("ovf error set", error, 1);
        chk("ovf no writes", n_wr - wbase, 0);
        for (int i = 5; i < 16; i++) drive(1'b1, bits[i], 1'b1);
        wait_done(dbase);
        chk_writes("ovf", wbase, 15, {1'b0, bits[15:5], bits[3:0]});
        chk("ovf done count", n_done - dbase, 1);
        chk("ovf error sticky", error, 1);
        chk("ovf busy after", busy, 0);

        // Excess input: 17th edge_valid arrives in DRAIN
        bits = 16'h9C3A;
        start_frame();
        chk("excess error cleared", error, 0);
        wbase = n_wr; dbase = n_done;
        for (int i = 0; i < 16; i++) drive(1'b1, bits[i], 1'b1);
        chk("excess error before", error, 0);
        drive(1'b1, 1'b1, 1'b1);
        chk("excess error set", error, 1);
        wait_done(dbase);
        chk_writes("excess", wbase, 16, bits);
        chk("excess done count", n_done - dbase, 1);
        chk("excess error sticky", error, 1);

        // Restart: frame_start after 7 pixels flushes a full FIFO and clears error
        start_frame();
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 1'b0);
        chk("restart error before", error, 1);
        bits = 16'h6A90;
        start_frame();
        chk("restart error cleared", error, 0);
        chk("restart busy", busy, 1);
        wbase = n_wr; dbase = n_done;
        for (int i = 0; i < 16; i++) drive(1'b1, bits[i], 1'b1);
        wait_done(dbase);
        chk_writes("restart", wbase, 16, bits);
        chk("restart done count", n_done - dbase, 1);

        // Reset mid-frame: outputs clear, frame abandoned silently
        start_frame();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b1);
        chk("midrst pre write_enable", write_enable, 1);
        chk("midrst pre address", write_address, 3);
        rst = 1'b1;
        edge_valid = 1'b1;
        step();
        chk_idle_outputs("midrst");
        rst = 1'b0;
        edge_valid = 1'b0;
        wbase = n_wr; dbase = n_done;
        for (int i = 0; i < 10; i++) step();
        chk("midrst no writes", n_wr - wbase, 0);
        chk("midrst no done", n_done - dbase, 0);
        chk("midrst busy", busy, 0);

        // All-ones frame: shows the border masking when it is compiled in
        bits = 16'hFFFF;
        start_frame();
        wbase = n_wr; dbase = n_done;
        for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 1'b1);
        wait_done(dbase);
        chk_writes("ones", wbase, 16, bits);
        chk("ones done count", n_done - dbase, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
